// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register address width, forwarding select codes,
// hazard controller state encoding and the NOP word used by the IF and ID stages.
package pipeline_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-register fields observed by the hazard controller and the
// stall/flush/forward controls it drives back into the IF, ID and EX stages.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] IF_ID_Rs1;
  logic [REG_AW-1:0] IF_ID_Rs2;
  logic              IF_ID_UsesRs2;
  logic [REG_AW-1:0] ID_EX_Rs1;
  logic [REG_AW-1:0] ID_EX_Rs2;
  logic [REG_AW-1:0] ID_EX_Rd;
  logic              ID_EX_MemRead;
  logic [REG_AW-1:0] EX_MEM_WriteReg;
  logic              EX_MEM_RegWrite;
  logic [REG_AW-1:0] MEM_WB_WriteReg;
  logic              MEM_WB_RegWrite;
  logic              EX_MEM_Branch;

  logic              PCWrite;
  logic              IF_ID_Write;
  logic              ID_EX_Bubble;
  logic              IF_ID_Flush;
  logic              ID_EX_Flush;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  // Pipeline side: publishes stage-register fields, consumes controls.
  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs2,
    output ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_MemRead,
    output EX_MEM_WriteReg, EX_MEM_RegWrite, MEM_WB_WriteReg, MEM_WB_RegWrite,
    output EX_MEM_Branch,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
    input  ForwardA, ForwardB, StallCount, FlushCount
  );

  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UsesRs2,
    input  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_MemRead,
    input  EX_MEM_WriteReg, EX_MEM_RegWrite, MEM_WB_WriteReg, MEM_WB_RegWrite,
    input  EX_MEM_Branch,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
    output ForwardA, ForwardB, StallCount, FlushCount
  );

endinterface

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX source register; EX/MEM wins over MEM/WB
// and register 0 never forwards.
module fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_exmem_reg,
  input  logic              i_exmem_wr,
  input  logic [REG_AW-1:0] i_memwb_reg,
  input  logic              i_memwb_wr,
  output logic [1:0]        o_sel
);
  import pipeline_pkg::*;

  always_comb begin
    o_sel = FWD_NONE;
    if (i_src != '0) begin
      if (i_exmem_wr && (i_exmem_reg == i_src)) begin
        o_sel = FWD_EXMEM;
      end else if (i_memwb_wr && (i_memwb_reg == i_src)) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall insertion, taken-branch flush,
// EX operand forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst,
  hazard_ctrl_if.slave bus
);
  import pipeline_pkg::*;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_e        r_state;
  logic [2:0]       r_stall_left;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic       w_lu;
  logic       w_pcwrite;
  logic       w_ifid_write;
  logic       w_bubble;
  logic       w_ifid_flush;
  logic       w_idex_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign w_lu = bus.ID_EX_MemRead && (bus.ID_EX_Rd != '0) &&
                ((bus.ID_EX_Rd == bus.IF_ID_Rs1) ||
                 (bus.IF_ID_UsesRs2 && (bus.ID_EX_Rd == bus.IF_ID_Rs2)));

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_src       (bus.ID_EX_Rs1),
    .i_exmem_reg (bus.EX_MEM_WriteReg),
    .i_exmem_wr  (bus.EX_MEM_RegWrite),
    .i_memwb_reg (bus.MEM_WB_WriteReg),
    .i_memwb_wr  (bus.MEM_WB_RegWrite),
    .o_sel       (w_fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_src       (bus.ID_EX_Rs2),
    .i_exmem_reg (bus.EX_MEM_WriteReg),
    .i_exmem_wr  (bus.EX_MEM_RegWrite),
    .i_memwb_reg (bus.MEM_WB_WriteReg),
    .i_memwb_wr  (bus.MEM_WB_RegWrite),
    .o_sel       (w_fwd_b)
  );

  // Mealy controls; a branch beats a pending or new stall, S_FLUSH ignores LU.
  always_comb begin
    w_pcwrite    = 1'b1;
    w_ifid_write = 1'b1;
    w_bubble     = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN, S_STALL: begin
          if (bus.EX_MEM_Branch) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if ((r_state == S_STALL) || w_lu) begin
            w_pcwrite    = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_stall_left  <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!w_pcwrite)   r_stall_count <= sat_inc(r_stall_count);
      if (w_ifid_flush) r_flush_count <= sat_inc(r_flush_count);
      case (r_state)
        S_RUN: begin
          if (bus.EX_MEM_Branch) begin
            r_state <= S_FLUSH;
          end else if (w_lu && (LOAD_STALL_CYCLES > 1)) begin
            r_stall_left <= STALL_RELOAD;
            r_state      <= S_STALL;
          end
        end
        S_STALL: begin
          if (bus.EX_MEM_Branch) begin
            r_stall_left <= '0;
            r_state      <= S_FLUSH;
          end else begin
            r_stall_left <= r_stall_left - 3'd1;
            if (r_stall_left == 3'd1) r_state <= S_RUN;
          end
        end
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign bus.PCWrite      = w_pcwrite;
  assign bus.IF_ID_Write  = w_ifid_write;
  assign bus.ID_EX_Bubble = w_bubble;
  assign bus.IF_ID_Flush  = w_ifid_flush;
  assign bus.ID_EX_Flush  = w_idex_flush;
  assign bus.ForwardA     = rst ? FWD_NONE : w_fwd_a;
  assign bus.ForwardB     = rst ? FWD_NONE : w_fwd_b;
  assign bus.StallCount   = r_stall_count;
  assign bus.FlushCount   = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one instance with a single-bubble load stall, one with
// a three-cycle stall, both driven by the same pipeline fields.
module tb_hazard_ctrl;

  bit   clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_wr_reg, wb_wr_reg;
  logic       id_us2, ex_mr, mem_rw, wb_rw, br;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus1 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus3 ();

  assign bus1.IF_ID_Rs1 = id_rs1;         assign bus3.IF_ID_Rs1 = id_rs1;
  assign bus1.IF_ID_Rs2 = id_rs2;         assign bus3.IF_ID_Rs2 = id_rs2;
  assign bus1.IF_ID_UsesRs2 = id_us2;     assign bus3.IF_ID_UsesRs2 = id_us2;
  assign bus1.ID_EX_Rs1 = ex_rs1;         assign bus3.ID_EX_Rs1 = ex_rs1;
  assign bus1.ID_EX_Rs2 = ex_rs2;         assign bus3.ID_EX_Rs2 = ex_rs2;
  assign bus1.ID_EX_Rd = ex_rd;           assign bus3.ID_EX_Rd = ex_rd;
  assign bus1.ID_EX_MemRead = ex_mr;      assign bus3.ID_EX_MemRead = ex_mr;
  assign bus1.EX_MEM_WriteReg = mem_wr_reg; assign bus3.EX_MEM_WriteReg = mem_wr_reg;
  assign bus1.EX_MEM_RegWrite = mem_rw;   assign bus3.EX_MEM_RegWrite = mem_rw;
  assign bus1.MEM_WB_WriteReg = wb_wr_reg; assign bus3.MEM_WB_WriteReg = wb_wr_reg;
  assign bus1.MEM_WB_RegWrite = wb_rw;    assign bus3.MEM_WB_RegWrite = wb_rw;
  assign bus1.EX_MEM_Branch = br;         assign bus3.EX_MEM_Branch = br;

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .bus(bus1));
  hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // Packed view: {PCWrite, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, FwdA, FwdB}
  localparam logic [8:0] IDLE = 9'b1_1_0_0_0_00_00;

  // Reference model: remaining forced bubbles, pending flush cycle, event tallies.
  int         stall_left [2];
  bit         flush_next [2];
  int         m_sc [2];
  int         m_fc [2];
  logic [8:0] exp_o [2];

  function automatic logic [8:0] pack(input int k);
    if (k == 0)
      return {bus1.PCWrite, bus1.IF_ID_Write, bus1.ID_EX_Bubble, bus1.IF_ID_Flush,
              bus1.ID_EX_Flush, bus1.ForwardA, bus1.ForwardB};
    return {bus3.PCWrite, bus3.IF_ID_Write, bus3.ID_EX_Bubble, bus3.IF_ID_Flush,
            bus3.ID_EX_Flush, bus3.ForwardA, bus3.ForwardB};
  endfunction

  function automatic logic [15:0] scnt(input int k);
    return (k == 0) ? bus1.StallCount : bus3.StallCount;
  endfunction

  function automatic logic [15:0] fcnt(input int k);
    return (k == 0) ? bus1.FlushCount : bus3.FlushCount;
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (mem_rw && mem_wr_reg == src) return 2'b10;
    if (wb_rw && wb_wr_reg == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit lu_ref();
    return ex_mr && ex_rd != 5'd0 &&
           (ex_rd == id_rs1 || (id_us2 && ex_rd == id_rs2));
  endfunction

  task automatic eval_model();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] ctl;
      if (rst)                               ctl = 5'b11000;
      else if (flush_next[k])                ctl = 5'b11000;
      else if (br)                           ctl = 5'b11011;
      else if (stall_left[k] > 0 || lu_ref()) ctl = 5'b00100;
      else                                   ctl = 5'b11000;
      exp_o[k] = rst ? {ctl, 4'b0000} : {ctl, fwd_ref(ex_rs1), fwd_ref(ex_rs2)};
    end
  endtask

  task automatic update_model();
    for (int k = 0; k < 2; k++) begin
      int lsc;
      lsc = (k == 0) ? 1 : 3;
      if (rst) begin
        stall_left[k] = 0; flush_next[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (!exp_o[k][8] && m_sc[k] < 65535) m_sc[k]++;
        if (exp_o[k][5] && m_fc[k] < 65535) m_fc[k]++;
        if (flush_next[k])          flush_next[k] = 0;
        else if (br)                begin flush_next[k] = 1; stall_left[k] = 0; end
        else if (stall_left[k] > 0) stall_left[k]--;
        else if (lu_ref())          stall_left[k] = lsc - 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    eval_model();
  endtask

  task automatic step();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_us2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_mr = 0; mem_wr_reg = 0; mem_rw = 0; wb_wr_reg = 0; wb_rw = 0; br = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample(); step(); rst = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mr = 1; ex_rd = 5'd4; id_rs1 = 5'd1; id_rs2 = 5'd4; id_us2 = 1;
    ex_rs1 = 5'd5; ex_rs2 = 5'd6;
  endtask

  task automatic test_reset();
    set_load_use(); br = 1; mem_rw = 1; mem_wr_reg = 5'd5;
    rst = 1'b1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pack(k) !== IDLE) begin
        bad++; $display("FAIL reset_out k=%0d got=%b want=%b", k, pack(k), IDLE);
      end
    end
    step();
    rst = 1'b0; clear_inputs();
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({scnt(k), fcnt(k)} !== 32'h0) begin
        bad++; $display("FAIL reset_cnt k=%0d got=%h/%h want=0/0", k, scnt(k), fcnt(k));
      end
    end
    step();
  endtask

  task automatic test_independent();
    do_reset();
    id_rs1 = 1; id_rs2 = 2; id_us2 = 1; ex_rs1 = 3; ex_rs2 = 4; ex_rd = 5; ex_mr = 1;
    mem_wr_reg = 6; mem_rw = 1; wb_wr_reg = 5; wb_rw = 1;
    for (int c = 0; c < 20; c++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        logic [8:0] o;
        o = pack(k);
        total++;
        if ({o[8], o[3:0]} !== 5'b1_0000) begin
          bad++; $display("FAIL indep k=%0d cyc=%0d got=%b want=10000", k, c, {o[8], o[3:0]});
        end
      end
      step();
    end
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (scnt(k) !== 16'd0) begin
        bad++; $display("FAIL indep_cnt k=%0d got=%0d want=0", k, scnt(k));
      end
    end
    step(); clear_inputs();
  endtask

  task automatic test_forward();
    logic [4:0] want [4];
    do_reset();
    want[0] = 5'b1_10_00; want[1] = 5'b1_01_00; want[2] = 5'b1_10_10; want[3] = 5'b1_01_00;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      ex_rs1 = 3; ex_rs2 = 9; id_rs1 = 10; id_rs2 = 11;
      case (c)
        0: begin mem_wr_reg = 3; mem_rw = 1; end
        1: begin mem_wr_reg = 7; mem_rw = 1; wb_wr_reg = 3; wb_rw = 1; end
        2: begin ex_rs2 = 3; mem_wr_reg = 3; mem_rw = 1; wb_wr_reg = 3; wb_rw = 1; end
        default: begin mem_wr_reg = 3; mem_rw = 0; wb_wr_reg = 3; wb_rw = 1; end
      endcase
      sample();
      begin
        logic [8:0] o;
        o = pack(0);
        total++;
        if ({o[8], o[3:0]} !== want[c]) begin
          bad++; $display("FAIL fwd cyc=%0d got=%b want=%b", c, {o[8], o[3:0]}, want[c]);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pack(k)[8:6] !== 3'b001) begin
        bad++; $display("FAIL lu_c0 k=%0d got=%b want=001", k, pack(k)[8:6]);
      end
    end
    step();
    ex_mr = 0; ex_rd = 0; mem_wr_reg = 4; mem_rw = 1;
    sample();
    total++;
    if (pack(0)[8:6] !== 3'b110) begin
      bad++; $display("FAIL lu_c1_u1 got=%b want=110", pack(0)[8:6]);
    end
    total++;
    if (pack(1)[8:6] !== 3'b001) begin
      bad++; $display("FAIL lu_c1_u3 got=%b want=001", pack(1)[8:6]);
    end
    step();
    ex_rs1 = 1; ex_rs2 = 4; mem_wr_reg = 0; mem_rw = 0; wb_wr_reg = 4; wb_rw = 1;
    id_rs1 = 8; id_rs2 = 9;
    sample();
    total++;
    if ({pack(0)[8], pack(0)[1:0]} !== 3'b1_01) begin
      bad++; $display("FAIL lu_c2_u1 got=%b want=101", {pack(0)[8], pack(0)[1:0]});
    end
    total++;
    if (pack(1)[8:6] !== 3'b001) begin
      bad++; $display("FAIL lu_c2_u3 got=%b want=001", pack(1)[8:6]);
    end
    step();
    clear_inputs();
    sample();
    total++;
    if (pack(1)[8] !== 1'b1) begin
      bad++; $display("FAIL lu_c3_u3 got=%b want=1", pack(1)[8]);
    end
    total++;
    if (scnt(0) !== 16'd1 || scnt(1) !== 16'd3) begin
      bad++; $display("FAIL lu_cnt got=%0d/%0d want=1/3", scnt(0), scnt(1));
    end
    step();
  endtask

  task automatic test_branch_in_stall();
    logic [4:0] want [4];
    do_reset();
    want[0] = 5'b00100; want[1] = 5'b11011; want[2] = 5'b11000; want[3] = 5'b11000;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) set_load_use(); else clear_inputs();
      br = (c == 1);
      sample();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (pack(k)[8:4] !== want[c]) begin
          bad++; $display("FAIL br_stall k=%0d cyc=%0d got=%b want=%b", k, c, pack(k)[8:4], want[c]);
        end
      end
      step();
    end
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (scnt(k) !== 16'd1 || fcnt(k) !== 16'd1) begin
        bad++; $display("FAIL br_cnt k=%0d got=%0d/%0d want=1/1", k, scnt(k), fcnt(k));
      end
    end
    step(); clear_inputs();
  endtask

  task automatic test_r0();
    do_reset();
    ex_mr = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_us2 = 1; ex_rs1 = 0; ex_rs2 = 0;
    mem_wr_reg = 0; mem_rw = 1; wb_wr_reg = 0; wb_rw = 1;
    for (int c = 0; c < 3; c++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (pack(k) !== IDLE) begin
          bad++; $display("FAIL r0 k=%0d cyc=%0d got=%b want=%b", k, c, pack(k), IDLE);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_load_use();
    sample(); step();
    rst = 1'b1;
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (pack(k) !== IDLE) begin
        bad++; $display("FAIL rst_mid_out k=%0d got=%b want=%b", k, pack(k), IDLE);
      end
    end
    step();
    rst = 1'b0; clear_inputs();
    sample();
    total++;
    if (pack(1)[8] !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pcw got=%b want=1", pack(1)[8]);
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({scnt(k), fcnt(k)} !== 32'h0) begin
        bad++; $display("FAIL rst_mid_cnt k=%0d got=%h/%h want=0/0", k, scnt(k), fcnt(k));
      end
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));  mem_wr_reg = 5'($urandom_range(0, 3));
      wb_wr_reg = 5'($urandom_range(0, 3));
      id_us2 = 1'($urandom); ex_mr = 1'($urandom); mem_rw = 1'($urandom);
      wb_rw = 1'($urandom);
      br = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      sample();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (pack(k) !== exp_o[k]) begin
          bad++; $display("FAIL rand_out k=%0d cyc=%0d got=%b want=%b", k, c, pack(k), exp_o[k]);
        end
        total++;
        if (scnt(k) !== 16'(m_sc[k]) || fcnt(k) !== 16'(m_fc[k])) begin
          bad++; $display("FAIL rand_cnt k=%0d cyc=%0d got=%0d/%0d want=%0d/%0d",
                          k, c, scnt(k), fcnt(k), m_sc[k], m_fc[k]);
        end
      end
      step();
    end
    rst = 1'b0; clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    for (int c = 0; c < 70000; c++) begin
      sample(); step();
    end
    sample();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (scnt(k) !== 16'hFFFF || fcnt(k) !== 16'h0) begin
        bad++; $display("FAIL sat k=%0d got=%h/%h want=ffff/0000", k, scnt(k), fcnt(k));
      end
    end
    step(); clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; flush_next[k] = 0; m_sc[k] = 0; m_fc[k] = 0; exp_o[k] = IDLE;
    end
    clear_inputs();
    test_reset();
    test_independent();
    test_forward();
    test_load_use();
    test_branch_in_stall();
    test_r0();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
